// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester command arbiter in front of a single-port RAM.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin contention, else fixed priority.
module ram_arbiter (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic       req0_we_i,
    input  logic [6:0] req0_addr_i,
    input  logic [7:0] req0_wdata_i,
    output logic       req0_rvalid_o,
    output logic [7:0] req0_rdata_o,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic       req1_we_i,
    input  logic [6:0] req1_addr_i,
    input  logic [7:0] req1_wdata_i,
    output logic       req1_rvalid_o,
    output logic [7:0] req1_rdata_o,
    output logic       ram_we_o,
    output logic [6:0] ram_addr_o,
    inout  wire  [7:0] ram_data_io,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] start_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic       id_q;
    logic       prio0;
    logic       grant0;
    logic       grant1;
    logic       accept;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic last_q;

    // Remember who was granted last; reset value lets requester 0 win first
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            last_q <= 1'b1;
        else if (accept)
            last_q <= grant1;
    end

    assign prio0 = last_q;
`else
    assign prio0 = 1'b1;
`endif

    assign accept = grant0 | grant1;

    // Next state and grant decode; grants only in IDLE once reset has settled
    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_q[1]) begin
                    grant0 = req0_valid_i & (~req1_valid_i | prio0);
                    grant1 = req1_valid_i & ~grant0;
                end
                if (grant0)
                    state_d = req0_we_i ? WR : RD;
                else if (grant1)
                    state_d = req1_we_i ? WR : RD;
            end
            WR:      state_d = IDLE;
            RD:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus a two-edge hold-off on ready after reset release
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            start_q <= 2'b00;
        end else begin
            state_q <= state_d;
            start_q <= {start_q[0], 1'b1};
        end
    end

    // Capture the granted command at the accept edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= 7'h00;
            wdata_q <= 8'h00;
            id_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= grant1 ? req1_addr_i : req0_addr_i;
            wdata_q <= grant1 ? req1_wdata_i : req0_wdata_i;
            id_q    <= grant1;
        end
    end

    // Register RAM read data at the end of RESP and pulse rvalid for one cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req0_rvalid_o <= 1'b0;
            req1_rvalid_o <= 1'b0;
            req0_rdata_o  <= 8'h00;
            req1_rdata_o  <= 8'h00;
        end else begin
            req0_rvalid_o <= 1'b0;
            req1_rvalid_o <= 1'b0;
            if (state_q == RESP) begin
                if (id_q) begin
                    req1_rvalid_o <= 1'b1;
                    req1_rdata_o  <= ram_data_io;
                end else begin
                    req0_rvalid_o <= 1'b1;
                    req0_rdata_o  <= ram_data_io;
                end
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign ram_we_o     = (state_q == WR);
    assign ram_addr_o   = addr_q;
    assign ram_data_io  = (state_q == WR) ? wdata_q : 8'hzz;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors, corner sequences and a randomized
// transaction-level model check for ram_arbiter.
module tb_ram_arbiter;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, we0 = 1'b0, v1 = 1'b0, we1 = 1'b0;
    logic [6:0] a0 = 7'h00, a1 = 7'h00;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       r0, r1, rv0, rv1, ram_we, busy;
    logic [7:0] rd0, rd1;
    logic [6:0] ram_addr;
    wire  [7:0] bus;
    logic [7:0] mem [128];
    logic [7:0] ref_mem [128];
    int         checks = 0;
    int         fails = 0;

    typedef struct {
        logic v0, v1, e0, e1;
    } vec_t;

    typedef struct {
        int         due;
        logic       id;
        logic [7:0] data;
    } exp_t;

    ram_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_we_i(we0),
        .req0_addr_i(a0), .req0_wdata_i(d0),
        .req0_rvalid_o(rv0), .req0_rdata_o(rd0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_we_i(we1),
        .req1_addr_i(a1), .req1_wdata_i(d1),
        .req1_rvalid_o(rv1), .req1_rdata_o(rd1),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_data_io(bus), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // RAM model: asynchronous read whenever not writing, write at clock edge
    assign bus = ram_we ? 8'hzz : mem[ram_addr];

    initial begin
        for (int i = 0; i < 128; i++)
            mem[i] = (i == 5) ? 8'h22 : 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (ram_we)
                mem[ram_addr] <= bus;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic look;
        #3;
    endtask

    initial begin
        vec_t       tab [7];
        exp_t       q [$];
        logic [7:0] last_rd [2];
        logic       found, seen, g0, g1, idle, e0, e1, cw;
        logic [6:0] ca;
        logic [7:0] cd;
        int         free_at, last;

        tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tab[2] = '{1'b1, 1'b1, !RR, RR};
        tab[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab[5] = '{1'b1, 1'b1, !RR, RR};
        tab[6] = '{1'b1, 1'b1, 1'b1, 1'b0};

        // Reset values, with both requesters already asking
        v0 = 1'b1; v1 = 1'b1;
        tick; tick; look;
        chk("rst_ready0", r0, 0);
        chk("rst_ready1", r1, 0);
        chk("rst_rvalid0", rv0, 0);
        chk("rst_rvalid1", rv1, 0);
        chk("rst_rdata0", rd0, 0);
        chk("rst_rdata1", rd1, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_released", bus, mem[0]);
        rst_n = 1'b1;
        #1;
        chk("release_ready0", r0, 0);
        chk("release_ready1", r1, 0);
        tick; look;
        chk("first_cycle_ready0", r0, 0);
        chk("first_cycle_ready1", r1, 0);
        tick;
        v0 = 1'b0; v1 = 1'b0;
        tick; tick;

        // Arbitration vectors (writes, applied from IDLE)
        for (int i = 0; i < 7; i++) begin
            v0 = tab[i].v0; we0 = 1'b1; a0 = 7'(7'h10 + i); d0 = 8'(i);
            v1 = tab[i].v1; we1 = 1'b1; a1 = 7'(7'h40 + i); d1 = 8'(i);
            look;
            chk("tab_ready0", r0, tab[i].e0);
            chk("tab_ready1", r1, tab[i].e1);
            chk("tab_busy_idle", busy, 0);
            tick;
            v0 = 1'b0; v1 = 1'b0;
            look;
            chk("tab_busy_wr", busy, tab[i].e0 | tab[i].e1);
            chk("tab_ram_we", ram_we, tab[i].e0 | tab[i].e1);
            if (tab[i].e0 | tab[i].e1)
                chk("tab_ram_addr", ram_addr,
                    tab[i].e1 ? 7'(7'h40 + i) : 7'(7'h10 + i));
            tick; tick;
        end

        // Single write then read by requester 0
        v0 = 1'b1; we0 = 1'b1; a0 = 7'h04; d0 = 8'h45;
        look;
        chk("w_accept", r0, 1);
        tick;
        v0 = 1'b0;
        look;
        chk("w_ram_we", ram_we, 1);
        chk("w_ram_addr", ram_addr, 7'h04);
        chk("w_bus", bus, 8'h45);
        chk("w_busy", busy, 1);
        tick; look;
        chk("w_done_we", ram_we, 0);
        chk("w_done_busy", busy, 0);
        chk("w_addr_hold", ram_addr, 7'h04);
        chk("w_mem", mem[4], 8'h45);
        v0 = 1'b1; we0 = 1'b0;
        look;
        chk("r_accept", r0, 1);
        tick;
        v0 = 1'b0;
        look;
        chk("r_rd_we", ram_we, 0);
        chk("r_rd_addr", ram_addr, 7'h04);
        chk("r_rd_rvalid", rv0, 0);
        tick; look;
        chk("r_resp_rvalid", rv0, 0);
        chk("r_resp_busy", busy, 1);
        tick; look;
        chk("r_rvalid", rv0, 1);
        chk("r_rdata", rd0, 8'h45);
        chk("r_rvalid_idle", busy, 0);
        tick; look;
        chk("r_rvalid_pulse", rv0, 0);
        chk("r_rdata_hold", rd0, 8'h45);

        // Back-to-back writes from requester 1
        v1 = 1'b1; we1 = 1'b1; a1 = 7'h7F; d1 = 8'hAA;
        look;
        chk("bb_accept1", r1, 1);
        tick;
        a1 = 7'h00; d1 = 8'h55;
        look;
        chk("bb_no_accept_in_wr", r1, 0);
        chk("bb_wr1_addr", ram_addr, 7'h7F);
        chk("bb_wr1_bus", bus, 8'hAA);
        tick; look;
        chk("bb_accept2", r1, 1);
        chk("bb_idle_we", ram_we, 0);
        chk("bb_idle_bus_released", bus, mem[7'h7F]);
        tick;
        v1 = 1'b0;
        look;
        chk("bb_wr2_addr", ram_addr, 7'h00);
        chk("bb_wr2_bus", bus, 8'h55);
        tick; look;
        chk("bb_done_busy", busy, 0);
        chk("bb_mem7f", mem[7'h7F], 8'hAA);
        chk("bb_mem00", mem[0], 8'h55);

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        // Round-robin contention: last grant was requester 1
        v0 = 1'b1; we0 = 1'b0; a0 = 7'h05;
        v1 = 1'b1; we1 = 1'b0; a1 = 7'h05;
        for (int k = 0; k < 5; k++) begin
            look;
            if (k < 4) begin
                chk("rr_grant0", r0, k % 2 == 0);
                chk("rr_grant1", r1, k % 2 == 1);
            end
            if (k > 0) begin
                chk("rr_rvalid0", rv0, (k - 1) % 2 == 0);
                chk("rr_rvalid1", rv1, (k - 1) % 2 == 1);
                chk("rr_rdata", (k - 1) % 2 == 0 ? rd0 : rd1, 8'h22);
            end
            tick;
            if (k == 3) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            if (k < 4) begin
                look;
                chk("rr_pulse_end", rv0 | rv1, 0);
                chk("rr_busy_ready", r0 | r1, 0);
                tick; look;
                chk("rr_resp_ready", r0 | r1, 0);
                tick;
            end
        end
        tick;
`else
        // Fixed priority: requester 1 starves while requester 0 keeps asking
        v0 = 1'b1; we0 = 1'b0; a0 = 7'h05;
        v1 = 1'b1; we1 = 1'b0; a1 = 7'h05;
        for (int k = 0; k < 20; k++) begin
            look;
            chk("fp_no_ready1", r1, 0);
            seen = r0;
            tick;
            if (k >= 8 && seen) begin
                v0 = 1'b0;
                break;
            end
        end
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            look;
            if (r1) found = 1'b1;
            tick;
        end
        v1 = 1'b0;
        chk("fp_ready1_after_drop", found, 1);
        tick; tick; tick;
`endif

        // Reset during RESP aborts the read
        v0 = 1'b1; we0 = 1'b0; a0 = 7'h04;
        look;
        chk("ra_accept", r0, 1);
        tick;
        v0 = 1'b0;
        tick; look;
        chk("ra_in_resp", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("ra_ready0", r0, 0);
        chk("ra_ready1", r1, 0);
        chk("ra_rvalid0", rv0, 0);
        chk("ra_rvalid1", rv1, 0);
        chk("ra_rdata0", rd0, 0);
        chk("ra_rdata1", rd1, 0);
        chk("ra_ram_we", ram_we, 0);
        chk("ra_ram_addr", ram_addr, 0);
        chk("ra_busy", busy, 0);
        tick; look;
        chk("ra_no_rvalid", rv0, 0);
        rst_n = 1'b1;
        tick; look;
        chk("ra_no_rvalid_after", rv0, 0);
        v0 = 1'b1; we0 = 1'b0; a0 = 7'h04;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            look;
            if (r0) found = 1'b1;
            tick;
        end
        v0 = 1'b0;
        chk("ra_reaccept", found, 1);
        tick; tick; look;
        chk("ra_read_rvalid", rv0, 1);
        chk("ra_read_rdata", rd0, 8'h45);
        tick;

        // Randomized traffic against a transaction-level model
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick; tick; tick;
        for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        free_at = 0;
        last = 1;
        for (int c = 0; c < 1500; c++) begin
            if (!v0 && $urandom_range(1, 0) == 1) begin
                v0 = 1'b1; we0 = 1'($urandom_range(1, 0));
                a0 = 7'($urandom_range(15, 0)); d0 = 8'($urandom_range(255, 0));
            end
            if (!v1 && $urandom_range(1, 0) == 1) begin
                v1 = 1'b1; we1 = 1'($urandom_range(1, 0));
                a1 = 7'($urandom_range(15, 0)); d1 = 8'($urandom_range(255, 0));
            end
            look;
            idle = (c >= free_at);
            g0 = idle && v0 && (!v1 || !RR || last == 1);
            g1 = idle && v1 && !g0;
            chk("rnd_ready0", r0, g0);
            chk("rnd_ready1", r1, g1);
            chk("rnd_busy", busy, !idle);
            e0 = q.size() > 0 && q[0].due == c && q[0].id == 1'b0;
            e1 = q.size() > 0 && q[0].due == c && q[0].id == 1'b1;
            chk("rnd_rvalid0", rv0, e0);
            chk("rnd_rvalid1", rv1, e1);
            if (e0 || e1) begin
                last_rd[q[0].id] = q[0].data;
                void'(q.pop_front());
            end
            chk("rnd_rdata0", rd0, last_rd[0]);
            chk("rnd_rdata1", rd1, last_rd[1]);
            if (g0 || g1) begin
                cw = g1 ? we1 : we0;
                ca = g1 ? a1 : a0;
                cd = g1 ? d1 : d0;
                if (cw) begin
                    ref_mem[ca] = cd;
                    free_at = c + 2;
                end else begin
                    q.push_back('{c + 3, g1, ref_mem[ca]});
                    free_at = c + 3;
                end
                last = g1 ? 1 : 0;
            end
            tick;
            if (g0) v0 = 1'b0;
            if (g1) v1 = 1'b0;
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
